// File: rtl/line_mem_ctrl.sv
// Write/read sequencer for the 10-word line memory ahead of the first convolution stage.
// Optional chip-port readback scanner is enabled by defining LMC_READBACK_EN.
module line_mem_ctrl #(
    parameter int DW         = 16,
    parameter int MEM_SIZE   = 10,
    parameter int MEM_ADDR   = 4,
    parameter int LINE_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DW-1:0]         s_data,
    output logic [DW-1:0]         mem_data_in,
    output logic [MEM_ADDR-1:0]   mem_in_add,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic                  line_valid,
    input  logic                  line_ack,
    output logic [LINE_CNT_W-1:0] line_cnt,
    input  logic                  rb_start,
    output logic                  rb_busy,
    output logic [MEM_ADDR-1:0]   chip_add,
    output logic                  chiprd_en,
    input  logic [DW-1:0]         mem_chip_data,
    output logic                  rb_valid,
    output logic [DW-1:0]         rb_data
);

    localparam logic [MEM_ADDR-1:0] LAST_ADDR = MEM_ADDR'(MEM_SIZE - 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [MEM_ADDR-1:0]     wr_ptr;
    logic [MEM_ADDR-1:0]     wr_ptr_nxt;
    logic [LINE_CNT_W-1:0]   line_cnt_nxt;
    logic                    accept;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= FILL;
            wr_ptr   <= '0;
            line_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            line_cnt <= line_cnt_nxt;
        end
    end

    // Write and parallel-read enables are decoded from exclusive states, so they can never overlap.
    always_comb begin
        state_nxt    = state;
        wr_ptr_nxt   = wr_ptr;
        line_cnt_nxt = line_cnt;
        s_ready      = 1'b0;
        mem_wr_en    = 1'b0;
        mem_rd_en    = 1'b0;
        line_valid   = 1'b0;
        accept       = 1'b0;
        case (state)
            FILL: begin
                s_ready   = 1'b1;
                mem_wr_en = s_valid;
                accept    = s_valid;
                if (accept) begin
                    if (wr_ptr == LAST_ADDR) begin
                        wr_ptr_nxt = '0;
                        state_nxt  = FULL;
                    end else begin
                        wr_ptr_nxt = wr_ptr + MEM_ADDR'(1);
                    end
                end
            end
            FULL: begin
                mem_rd_en  = 1'b1;
                line_valid = 1'b1;
                if (line_ack) begin
                    state_nxt    = FILL;
                    line_cnt_nxt = line_cnt + LINE_CNT_W'(1);
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    assign mem_in_add  = wr_ptr;
    assign mem_data_in = s_data;

`ifdef LMC_READBACK_EN
    logic                rb_busy_q;
    logic [MEM_ADDR-1:0] chip_add_q;
    logic                vld_p1;
    logic [DW-1:0]       rb_data_p1;

    // Stage p0: address issue on the chip port; stage p1: captured read word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rb_busy_q  <= 1'b0;
            chip_add_q <= '0;
            vld_p1     <= 1'b0;
            rb_data_p1 <= '0;
        end else begin
            vld_p1 <= rb_busy_q;
            if (rb_busy_q) begin
                rb_data_p1 <= mem_chip_data;
                if (chip_add_q == LAST_ADDR) begin
                    rb_busy_q  <= 1'b0;
                    chip_add_q <= '0;
                end else begin
                    chip_add_q <= chip_add_q + MEM_ADDR'(1);
                end
            end else if (rb_start) begin
                rb_busy_q  <= 1'b1;
                chip_add_q <= '0;
            end
        end
    end

    assign rb_busy   = rb_busy_q;
    assign chiprd_en = rb_busy_q;
    assign chip_add  = chip_add_q;
    assign rb_valid  = vld_p1;
    assign rb_data   = rb_data_p1;
`else
    logic unused_rb;
    assign unused_rb = &{1'b0, rb_start, mem_chip_data};

    assign rb_busy   = 1'b0;
    assign chiprd_en = 1'b0;
    assign chip_add  = '0;
    assign rb_valid  = 1'b0;
    assign rb_data   = '0;
`endif

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Directed bench for line_mem_ctrl with a behavioural 16-word memory attached.
module tb_line_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic [15:0] mem_data_in;
    logic [3:0]  mem_in_add;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic        line_valid;
    logic        line_ack;
    logic [7:0]  line_cnt;
    logic        rb_start;
    logic        rb_busy;
    logic [3:0]  chip_add;
    logic        chiprd_en;
    logic [15:0] mem_chip_data;
    logic        rb_valid;
    logic [15:0] rb_data;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] mem    [0:15];
    logic [3:0]  wlog_a [0:4095];
    logic [15:0] wlog_d [0:4095];
    int          wn       = 0;
    int          both_err = 0;

    line_mem_ctrl dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .mem_data_in(mem_data_in), .mem_in_add(mem_in_add), .mem_wr_en(mem_wr_en),
        .mem_rd_en(mem_rd_en), .line_valid(line_valid), .line_ack(line_ack), .line_cnt(line_cnt),
        .rb_start(rb_start), .rb_busy(rb_busy), .chip_add(chip_add), .chiprd_en(chiprd_en),
        .mem_chip_data(mem_chip_data), .rb_valid(rb_valid), .rb_data(rb_data)
    );

    always #5 clk = ~clk;

    assign mem_chip_data = mem[chip_add];

    always @(posedge clk) begin
        if (mem_wr_en && !mem_rd_en) begin
            mem[mem_in_add] <= mem_data_in;
            wlog_a[wn[11:0]] <= mem_in_add;
            wlog_d[wn[11:0]] <= mem_data_in;
            wn <= wn + 1;
        end
        if (mem_wr_en && mem_rd_en) both_err <= both_err + 1;
    end

    task automatic stream_line(input logic [15:0] base);
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = base + 16'(i);
            #1;
            n_chk++;
            if ({s_ready, mem_wr_en, line_valid, mem_rd_en} !== 4'b1100 || mem_in_add !== 4'(i)
                || mem_data_in !== s_data) begin
                $display("FAIL stream_wr[%0d]: ready/wr/lv/rd=%b add=%0d data=%h, want 1100 add=%0d data=%h",
                         i, {s_ready, mem_wr_en, line_valid, mem_rd_en}, mem_in_add, mem_data_in, i, s_data);
            end else n_pass++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_data  = 16'h0;
        #1;
        n_chk++;
        if ({s_ready, mem_wr_en, line_valid, mem_rd_en} !== 4'b0011) begin
            $display("FAIL line_full: ready/wr/lv/rd=%b want 0011", {s_ready, mem_wr_en, line_valid, mem_rd_en});
        end else n_pass++;
    endtask

    task automatic ack_line(input logic [7:0] exp_cnt);
        line_ack = 1'b1;
        @(posedge clk); #1;
        line_ack = 1'b0;
        n_chk++;
        if ({s_ready, line_valid, mem_rd_en} !== 3'b100 || line_cnt !== exp_cnt) begin
            $display("FAIL ack: ready/lv/rd=%b cnt=%0d, want 100 cnt=%0d",
                     {s_ready, line_valid, mem_rd_en}, line_cnt, exp_cnt);
        end else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b0; s_valid = 1'b0; s_data = 16'h0; line_ack = 1'b0; rb_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({s_ready, mem_wr_en, mem_rd_en, line_valid} !== 4'b1000 || mem_in_add !== 4'd0
            || line_cnt !== 8'd0) begin
            $display("FAIL reset_ctrl: ready/wr/rd/lv=%b add=%0d cnt=%0d, want 1000 0 0",
                     {s_ready, mem_wr_en, mem_rd_en, line_valid}, mem_in_add, line_cnt);
        end else n_pass++;
        n_chk++;
        if ({rb_busy, chiprd_en, rb_valid} !== 3'b000 || chip_add !== 4'd0 || rb_data !== 16'h0) begin
            $display("FAIL reset_rb: busy/rd/vld=%b add=%0d data=%h, want 000 0 0000",
                     {rb_busy, chiprd_en, rb_valid}, chip_add, rb_data);
        end else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        int w0;
        w0 = wn;
        stream_line(16'd1);
        n_chk++;
        if (wn - w0 !== 10) $display("FAIL fill_count: writes=%0d want 10", wn - w0);
        else n_pass++;
    endtask

    task automatic test_hold_ack();
        int w0;
        w0 = wn;
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_chk++;
            if ({line_valid, mem_rd_en, mem_wr_en, s_ready} !== 4'b1100) begin
                $display("FAIL hold[%0d]: lv/rd/wr/ready=%b want 1100", c, {line_valid, mem_rd_en, mem_wr_en, s_ready});
            end else n_pass++;
        end
        s_valid = 1'b0;
        n_chk++;
        if (wn !== w0) $display("FAIL hold_writes: writes=%0d want 0", wn - w0);
        else n_pass++;
        ack_line(8'd1);
    endtask

    task automatic test_toggle();
        int w0;
        w0 = wn;
        for (int k = 0; k < 20; k++) begin
            s_valid = (k % 2 == 0);
            s_data  = s_valid ? 16'h100 + 16'(k / 2) : 16'hDEAD;
            #1;
            n_chk++;
            if (mem_wr_en !== s_valid || mem_data_in !== s_data) begin
                $display("FAIL toggle_en[%0d]: wr=%b data=%h, want wr=%b data=%h",
                         k, mem_wr_en, mem_data_in, s_valid, s_data);
            end else n_pass++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        n_chk++;
        if (wn - w0 !== 10 || line_valid !== 1'b1) begin
            $display("FAIL toggle_count: writes=%0d lv=%b, want 10 1", wn - w0, line_valid);
        end else n_pass++;
        for (int j = 0; j < 10; j++) begin
            n_chk++;
            if (wlog_a[w0 + j] !== 4'(j) || wlog_d[w0 + j] !== 16'h100 + 16'(j)) begin
                $display("FAIL toggle_log[%0d]: add=%0d data=%h, want add=%0d data=%h",
                         j, wlog_a[w0 + j], wlog_d[w0 + j], j, 16'h100 + 16'(j));
            end else n_pass++;
        end
        ack_line(8'd2);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 16'h50 + 16'(i);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        reset   = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        n_chk++;
        if (mem_in_add !== 4'd0 || line_cnt !== 8'd0 || {s_ready, line_valid} !== 2'b10) begin
            $display("FAIL mid_reset: add=%0d cnt=%0d ready/lv=%b, want 0 0 10",
                     mem_in_add, line_cnt, {s_ready, line_valid});
        end else n_pass++;
        stream_line(16'h200);
        ack_line(8'd1);
    endtask

    task automatic test_back_to_back();
        int w0;
        w0 = wn;
        s_valid  = 1'b1;
        line_ack = 1'b1;
        s_data   = 16'h300;
        repeat (254 * 11) @(posedge clk);
        #1;
        n_chk++;
        if (line_cnt !== 8'd255 || wn - w0 !== 2540 || line_valid !== 1'b0) begin
            $display("FAIL b2b_rate: cnt=%0d writes=%0d lv=%b, want 255 2540 0", line_cnt, wn - w0, line_valid);
        end else n_pass++;
        repeat (10) @(posedge clk);
        #1;
        n_chk++;
        if (line_valid !== 1'b1 || mem_wr_en !== 1'b0) begin
            $display("FAIL b2b_full: lv=%b wr=%b, want 1 0", line_valid, mem_wr_en);
        end else n_pass++;
        @(posedge clk); #1;
        s_valid  = 1'b0;
        line_ack = 1'b0;
        n_chk++;
        if (line_cnt !== 8'd0 || line_valid !== 1'b0) begin
            $display("FAIL cnt_wrap: cnt=%0d lv=%b, want 0 0", line_cnt, line_valid);
        end else n_pass++;
    endtask

    task automatic test_readback();
        logic       e_vld;
        logic       e_busy;
        logic [3:0] e_add;
        stream_line(16'hA0);
        ack_line(8'd1);
        rb_start = 1'b1;
        @(posedge clk); #1;
        rb_start = 1'b0;
`ifdef LMC_READBACK_EN
        n_chk++;
        if ({rb_busy, chiprd_en, rb_valid} !== 3'b110 || chip_add !== 4'd0) begin
            $display("FAIL rb_start: busy/rd/vld=%b add=%0d, want 110 0", {rb_busy, chiprd_en, rb_valid}, chip_add);
        end else n_pass++;
`endif
        for (int j = 1; j <= 12; j++) begin
            rb_start = (j == 3);
            @(posedge clk); #1;
`ifdef LMC_READBACK_EN
            e_vld  = (j <= 10);
            e_busy = (j < 10);
            e_add  = e_busy ? 4'(j) : 4'd0;
            n_chk++;
            if ({rb_valid, rb_busy, chiprd_en} !== {e_vld, e_busy, e_busy} || chip_add !== e_add
                || (e_vld && rb_data !== 16'hA0 + 16'(j - 1))) begin
                $display("FAIL rb_scan[%0d]: vld/busy/rd=%b add=%0d data=%h, want %b add=%0d data=%h",
                         j, {rb_valid, rb_busy, chiprd_en}, chip_add, rb_data,
                         {e_vld, e_busy, e_busy}, e_add, 16'hA0 + 16'(j - 1));
            end else n_pass++;
`else
            e_vld = 1'b0; e_busy = 1'b0; e_add = 4'd0;
            n_chk++;
            if ({rb_valid, rb_busy, chiprd_en} !== {e_vld, e_busy, e_busy} || chip_add !== e_add
                || rb_data !== 16'h0) begin
                $display("FAIL rb_off[%0d]: vld/busy/rd=%b add=%0d data=%h, want 000 0 0000",
                         j, {rb_valid, rb_busy, chiprd_en}, chip_add, rb_data);
            end else n_pass++;
`endif
        end
        rb_start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hold_ack();
        test_toggle();
        test_mid_reset();
        test_back_to_back();
        test_readback();
        n_chk++;
        if (both_err !== 0) $display("FAIL wr_rd_overlap: cycles=%0d want 0", both_err);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
